// File: rtl/bw_clk_seq_pkg.sv
// Shared types and constants for the DDR pad clock cluster sequencer.
// State encoding, per-state header output vectors and default timing counts.
package bw_clk_seq_pkg;

  localparam int unsigned DefCkenDly    = 4;
  localparam int unsigned DefGrstCycles = 8;
  localparam int unsigned DefDbgCycles  = 3;
  localparam int unsigned DefCntW       = 8;

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StCken = 3'd1,
    StGrst = 3'd2,
    StRun  = 3'd3,
    StWrst = 3'd4,
    StDbg  = 3'd5,
    StStop = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic cken;
    logic grst_l;
    logic gdbginit_l;
    logic ready;
  } seq_out_t;

  localparam seq_out_t OutOff  = '{cken: 1'b0, grst_l: 1'b0, gdbginit_l: 1'b0, ready: 1'b0};
  localparam seq_out_t OutCken = '{cken: 1'b1, grst_l: 1'b0, gdbginit_l: 1'b0, ready: 1'b0};
  localparam seq_out_t OutGrst = '{cken: 1'b1, grst_l: 1'b0, gdbginit_l: 1'b0, ready: 1'b0};
  localparam seq_out_t OutRun  = '{cken: 1'b1, grst_l: 1'b1, gdbginit_l: 1'b1, ready: 1'b1};
  localparam seq_out_t OutWrst = '{cken: 1'b1, grst_l: 1'b0, gdbginit_l: 1'b1, ready: 1'b0};
  localparam seq_out_t OutDbg  = '{cken: 1'b1, grst_l: 1'b1, gdbginit_l: 1'b0, ready: 1'b0};
  localparam seq_out_t OutStop = '{cken: 1'b0, grst_l: 1'b1, gdbginit_l: 1'b1, ready: 1'b0};

  function automatic seq_out_t state_out(input seq_state_e st);
    seq_out_t o;
    case (st)
      StCken:  o = OutCken;
      StGrst:  o = OutGrst;
      StRun:   o = OutRun;
      StWrst:  o = OutWrst;
      StDbg:   o = OutDbg;
      StStop:  o = OutStop;
      default: o = OutOff;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bw_clk_seq_cnt.sv
// Loadable down-counter used to time the sequencer's fixed-length states.
// Saturates at zero; load has priority over decrement.
module bw_clk_seq_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/bw_clk_cl_ddr_seq.sv
// Clock-enable / reset sequencer for the DDR cluster header: power-up, warm reset,
// debug-init and clock-stop, with registered outputs decoded from the next state.
module bw_clk_cl_ddr_seq
  import bw_clk_seq_pkg::*;
#(
  parameter int unsigned CKEN_DLY    = DefCkenDly,
  parameter int unsigned GRST_CYCLES = DefGrstCycles,
  parameter int unsigned DBG_CYCLES  = DefDbgCycles,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic rclk,
  input  logic arst_l,
  input  logic start,
  input  logic wrst_req,
  input  logic dbg_req,
  input  logic stop_req,
  output logic cluster_cken,
  output logic grst_l,
  output logic gdbginit_l,
  output logic wrst_ack,
  output logic dbg_ack,
  output logic ready
);

  localparam logic [CNT_W-1:0] CkenLoad = CNT_W'(CKEN_DLY - 1);
  localparam logic [CNT_W-1:0] GrstLoad = CNT_W'(GRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DbgLoad  = CNT_W'(DBG_CYCLES - 1);

  seq_state_e       state_q, state_d;
  seq_out_t         out_q;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  bw_clk_seq_cnt #(
    .Width (CNT_W)
  ) u_cnt (
    .clk      (rclk),
    .rst_l    (arst_l),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  assign cnt_en = (state_q == StCken) || (state_q == StGrst) ||
                  (state_q == StWrst) || (state_q == StDbg);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff:  if (start) state_d = StCken;
      StCken: if (cnt_zero) state_d = StGrst;
      StGrst: if (cnt_zero) state_d = StRun;
      StRun: begin
        // The request being acked this cycle is still allowed to be high; ignore it.
        if (stop_req)                    state_d = StStop;
        else if (wrst_req && !wrst_ack)  state_d = StWrst;
        else if (dbg_req && !dbg_ack)    state_d = StDbg;
      end
      StWrst: if (cnt_zero) state_d = StRun;
      StDbg:  if (cnt_zero) state_d = StRun;
      StStop: if (!stop_req) state_d = StRun;
      default: state_d = StOff;
    endcase
  end

  always_comb begin
    cnt_load = (state_d != state_q);
    cnt_val  = '0;
    case (state_d)
      StCken:  cnt_val = CkenLoad;
      StGrst:  cnt_val = GrstLoad;
      StWrst:  cnt_val = GrstLoad;
      StDbg:   cnt_val = DbgLoad;
      default: cnt_val = '0;
    endcase
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q  <= StOff;
      out_q    <= OutOff;
      wrst_ack <= 1'b0;
      dbg_ack  <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= state_out(state_d);
      wrst_ack <= (state_q == StWrst) && cnt_zero;
      dbg_ack  <= (state_q == StDbg) && cnt_zero;
    end
  end

  assign cluster_cken = out_q.cken;
  assign grst_l       = out_q.grst_l;
  assign gdbginit_l   = out_q.gdbginit_l;
  assign ready        = out_q.ready;

endmodule

// File: tb/tb_bw_clk_cl_ddr_seq.sv
// Directed bench for bw_clk_cl_ddr_seq: default-count instance plus an all-ones instance.
// A negedge monitor checks every ack against a queue of expected operations.
module tb_bw_clk_cl_ddr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_l, start, wrst_req, dbg_req, stop_req;
  logic cken, grst_l, gdbg_l, wack, dack, rdy;
  logic start_m, wrst_m, dbg_m, stop_m;
  logic cken_m, grst_m, gdbg_m, wack_m, dack_m, rdy_m;

  bw_clk_cl_ddr_seq u_dut (
    .rclk         (clk),
    .arst_l       (arst_l),
    .start        (start),
    .wrst_req     (wrst_req),
    .dbg_req      (dbg_req),
    .stop_req     (stop_req),
    .cluster_cken (cken),
    .grst_l       (grst_l),
    .gdbginit_l   (gdbg_l),
    .wrst_ack     (wack),
    .dbg_ack      (dack),
    .ready        (rdy)
  );

  bw_clk_cl_ddr_seq #(
    .CKEN_DLY    (1),
    .GRST_CYCLES (1),
    .DBG_CYCLES  (1)
  ) u_dut_min (
    .rclk         (clk),
    .arst_l       (arst_l),
    .start        (start_m),
    .wrst_req     (wrst_m),
    .dbg_req      (dbg_m),
    .stop_req     (stop_m),
    .cluster_cken (cken_m),
    .grst_l       (grst_m),
    .gdbginit_l   (gdbg_m),
    .wrst_ack     (wack_m),
    .dbg_ack      (dack_m),
    .ready        (rdy_m)
  );

  typedef struct {
    bit          is_dbg;
    int unsigned len;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int unsigned n_asserts = 0;
  int unsigned n_fails = 0;
  int unsigned wlow = 0;
  int unsigned dlow = 0;
  bit          got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count header-low cycles per operation and score them when the ack appears.
  always @(negedge clk) begin
    if (!arst_l) begin
      wlow = 0;
      dlow = 0;
    end else begin
      if (cken && !grst_l && gdbg_l) wlow++;
      if (cken && grst_l && !gdbg_l) dlow++;
      if (wack || dack) begin
        check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          sb_e = sb_q.pop_front();
          check("sb_kind", {31'd0, dack}, {31'd0, sb_e.is_dbg});
          check("sb_len", sb_e.is_dbg ? dlow : wlow, sb_e.len);
        end
        wlow = 0;
        dlow = 0;
      end
    end
  end

  initial begin
    arst_l = 1'b0; start = 1'b0; wrst_req = 1'b0; dbg_req = 1'b0; stop_req = 1'b0;
    start_m = 1'b0; wrst_m = 1'b0; dbg_m = 1'b0; stop_m = 1'b0;
    #12;
    check("reset_outs", {26'd0, cken, grst_l, gdbg_l, wack, dack, rdy}, 32'd0);
    check("reset_outs_min", {26'd0, cken_m, grst_m, gdbg_m, wack_m, dack_m, rdy_m}, 32'd0);
    @(posedge clk); #1;
    arst_l = 1'b1;
    tick(1);
    check("off_idle", {29'd0, cken, grst_l, rdy}, 32'd0);

    // Power-up on both instances.
    start = 1'b1; start_m = 1'b1;
    tick(1);
    check("pu_cken", {30'd0, cken, grst_l}, 32'b10);
    check("pu_min_cken", {30'd0, cken_m, rdy_m}, 32'b10);
    start = 1'b0; start_m = 1'b0;
    tick(1);
    check("pu_min_t1", {30'd0, grst_m, rdy_m}, 32'b00);
    tick(1);
    check("pu_min_t2", {30'd0, grst_m, rdy_m}, 32'b11);
    tick(9);
    check("pu_t11", {30'd0, grst_l, rdy}, 32'b00);
    tick(1);
    check("pu_t12", {28'd0, cken, grst_l, gdbg_l, rdy}, 32'b1111);

    // Warm reset, default counts.
    wrst_req = 1'b1;
    sb_q.push_back('{is_dbg: 1'b0, len: 8});
    tick(1);
    check("wrst_enter", {28'd0, cken, grst_l, gdbg_l, rdy}, 32'b1010);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      check("wrst_hold", {30'd0, cken, grst_l}, 32'b10);
    end
    tick(1);
    check("wrst_done", {29'd0, grst_l, wack, rdy}, 32'b111);
    wrst_req = 1'b0;
    tick(1);
    check("wrst_ack_once", {30'd0, wack, rdy}, 32'b01);

    // Warm reset, all-ones counts.
    wrst_m = 1'b1;
    tick(1);
    check("min_wrst", {29'd0, cken_m, grst_m, rdy_m}, 32'b100);
    tick(1);
    check("min_wrst_done", {29'd0, grst_m, wack_m, rdy_m}, 32'b111);
    wrst_m = 1'b0;
    tick(1);
    check("min_wrst_ack_once", {31'd0, wack_m}, 32'd0);

    // Simultaneous requests: stop wins, then warm reset, then debug-init.
    stop_req = 1'b1; wrst_req = 1'b1; dbg_req = 1'b1;
    sb_q.push_back('{is_dbg: 1'b0, len: 8});
    sb_q.push_back('{is_dbg: 1'b1, len: 3});
    tick(1);
    check("stop_enter", {28'd0, cken, grst_l, gdbg_l, rdy}, 32'b0110);
    tick(3);
    check("stop_hold", {30'd0, cken, rdy}, 32'b00);
    stop_req = 1'b0;
    tick(1);
    check("stop_exit", {30'd0, cken, rdy}, 32'b11);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (wack) got = 1'b1;
    end
    check("sim_wack_seen", {31'd0, got}, 32'd1);
    wrst_req = 1'b0;
    tick(1);
    check("sim_dbg_after_gap", {30'd0, gdbg_l, rdy}, 32'b00);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (dack) got = 1'b1;
    end
    check("sim_dack_seen", {31'd0, got}, 32'd1);
    dbg_req = 1'b0;
    tick(2);

    // Debug request held one cycle past its ack starts a second debug-init.
    dbg_req = 1'b1;
    sb_q.push_back('{is_dbg: 1'b1, len: 3});
    sb_q.push_back('{is_dbg: 1'b1, len: 3});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (dack) got = 1'b1;
    end
    check("held_dack1", {31'd0, got}, 32'd1);
    tick(1);
    check("held_gap", {30'd0, gdbg_l, rdy}, 32'b11);
    tick(1);
    check("held_redo", {30'd0, gdbg_l, rdy}, 32'b00);
    dbg_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (dack) got = 1'b1;
    end
    check("held_dack2", {31'd0, got}, 32'd1);
    tick(2);

    // Reset in the fifth cycle of a warm reset.
    wrst_req = 1'b1;
    tick(5);
    check("abort_in_wrst", {30'd0, cken, grst_l}, 32'b10);
    #2;
    arst_l = 1'b0;
    #1;
    check("abort_async", {26'd0, cken, grst_l, gdbg_l, wack, dack, rdy}, 32'd0);
    wrst_req = 1'b0;
    tick(2);
    check("abort_held", {26'd0, cken, grst_l, gdbg_l, wack, dack, rdy}, 32'd0);
    arst_l = 1'b1;
    tick(3);
    check("abort_off", {29'd0, cken, wack, rdy}, 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("repu_cken", {30'd0, cken, grst_l}, 32'b10);
    tick(11);
    check("repu_t11", {31'd0, rdy}, 32'd0);
    tick(1);
    check("repu_t12", {30'd0, grst_l, rdy}, 32'b11);
    tick(2);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/bw_clk_cl_ddr_seq.md
# bw_clk_cl_ddr_seq

Clock-enable and reset sequencer for the DDR pad clock cluster. It drives the cluster header's `cluster_cken`, `grst_l` and `gdbginit_l` inputs in the order the header's synchronizers require: power-up, warm reset, debug-init and clock-stop. It sits beside the DDR cluster header in the pad ring and answers level requests from the CTU with single-cycle acknowledge pulses.

## Interface
- `CKEN_DLY`, default 4: cycles `cluster_cken` is high before `grst_l` may deassert. Minimum 1.
- `GRST_CYCLES`, default 8: cycles `grst_l` is held low per reset. Minimum 1.
- `DBG_CYCLES`, default 3: cycles `gdbginit_l` is held low per debug-init. Minimum 1.
- `CNT_W`, default 8: counter width. Each of the three counts above must be ≤ 2^CNT_W.
- `rclk`, in, 1: the only clock; rising edge.
- `arst_l`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: power-up sequence go; sampled only in OFF.
- `wrst_req`, in, 1: warm-reset request; a level held until `wrst_ack`.
- `dbg_req`, in, 1: debug-init request; a level held until `dbg_ack`.
- `stop_req`, in, 1: clock-stop request; a level.
- `cluster_cken`, out, 1: goes to the header `cluster_cken`.
- `grst_l`, out, 1: goes to the header `grst_l`.
- `gdbginit_l`, out, 1: goes to the header `gdbginit_l`.
- `wrst_ack`, out, 1: one-cycle pulse when a warm reset completes.
- `dbg_ack`, out, 1: one-cycle pulse when a debug-init completes.
- `ready`, out, 1: high while in RUN.

## Operation
- **States:** OFF, CKEN, GRST, RUN, WRST, DBG, STOP.
- **Outputs:** all are registered, decoded from the next state, and change on the same edge the state changes.
  - OFF: cken=0, grst_l=0, gdbginit_l=0.
  - CKEN: cken=1, grst_l=0, gdbginit_l=0.
  - GRST: cken=1, grst_l=0, gdbginit_l=0.
  - RUN: cken=1, grst_l=1, gdbginit_l=1, ready=1.
  - WRST: cken=1, grst_l=0, gdbginit_l=1.
  - DBG: cken=1, grst_l=1, gdbginit_l=0.
  - STOP: cken=0, grst_l=1, gdbginit_l=1.
- **Transitions:**
  - OFF → CKEN when `start`=1.
  - CKEN → GRST when the counter expires.
  - GRST → RUN when the counter expires.
  - In RUN, priority is `stop_req` > `wrst_req` > `dbg_req`, giving RUN → STOP, RUN → WRST or RUN → DBG.
  - WRST → RUN on expiry, pulsing `wrst_ack` in the first RUN cycle.
  - DBG → RUN on expiry, pulsing `dbg_ack` in the first RUN cycle.
  - STOP → RUN when `stop_req`=0.
- **Counter:** loaded with N−1 on entry to CKEN, GRST, WRST or DBG, then decrements each cycle. The state exits on the cycle the count is 0, so the state lasts exactly N cycles.
- **Request sampling:**
  - Requests are sampled only in RUN. Requests raised during any other state remain pending because they are levels.
  - After an ack, the requester must drop its request before the next cycle. A request still high in the cycle after its ack starts a new operation.
- **Simultaneous requests:** the highest priority request is served. Lower-priority requests still asserted are served on later RUN cycles.
- **Reset mid-operation:** `arst_l` low in any state forces OFF and the reset output values immediately, asynchronously. No ack is issued for an aborted operation.
- **Non-preemption:** WRST and DBG are not preempted by `stop_req`. The stop is taken on return to RUN.

## Timing
- **Reset values:** cluster_cken=0, grst_l=0, gdbginit_l=0, wrst_ack=0, dbg_ack=0, ready=0, state=OFF, counter=0.
- **Power-up latency:**
  - `start` is sampled high at edge t.
  - `cluster_cken` rises at t.
  - `grst_l` rises at t + CKEN_DLY + GRST_CYCLES.
  - `ready` rises in the same cycle as `grst_l`.
- **Warm reset:**
  - `wrst_req` is sampled in RUN at edge t.
  - `grst_l` is low for edges t through t + GRST_CYCLES − 1.
  - `wrst_ack` pulses for the one cycle following edge t + GRST_CYCLES.
- **Debug-init:** same timing as warm reset with DBG_CYCLES.
- **RUN gap:** at least one RUN cycle always separates consecutive operations.

## Structure
- **Shared package (`bw_clk_seq_pkg`):** holds the state enum (3-bit, binary), the per-state output-vector constants and the default parameter values.
- **Sub-module `bw_clk_seq_cnt`:** a loadable down-counter with load value, enable and a `zero` flag. It is the only sub-module. The FSM and output registers stay in the top.

## Test plan
- **Power-up:** reset, then `start` pulse → `cluster_cken`=1 after 1 edge, `grst_l`=1 and `ready`=1 exactly 12 edges after `start` (4+8 with defaults).
- **Warm reset:** in RUN, `wrst_req` high → `grst_l` low for exactly 8 cycles, `cluster_cken` stays 1, one `wrst_ack` pulse, then RUN.
- **Simultaneous requests:** `wrst_req`, `dbg_req` and `stop_req` raised together → STOP until `stop_req` drops, then WRST (8 cycles) with ack, then at least 1 RUN cycle, then DBG (3 cycles) with ack.
- **Reset mid-operation:** `arst_l` asserted in cycle 5 of WRST → all outputs at reset values with no clock edge, no `wrst_ack`, and a full power-up sequence required after `start`.
- **Request held too long:** `dbg_req` kept high one cycle past `dbg_ack` → a second DBG sequence runs, with `gdbginit_l` low for 3 cycles again.
- **Minimum parameters:** all three counts set to 1 → power-up reaches RUN 2 edges after `start`; WRST lasts 1 cycle with correct ack.
